// File: rtl/mux_rr_arbiter_16.sv
// Round-robin arbiter driving a 16:1 MUX (grant/select/enable) with IDLE/GRANT/GAP sequencing.
// Optional grant timeout enabled by defining MUX_RR_TIMEOUT_EN (uses MAX_HOLD).
module mux_rr_arbiter_16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic [15:0] Request_In,
  output logic [15:0] Grant_Out,
  output logic [3:0]  Select_Out,
  output logic        Enable_Out,
  output logic        Timeout_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_owner;
  logic [3:0]  w_owner_next;
  logic [3:0]  r_last_ptr;
  logic [3:0]  w_last_ptr_next;
  logic [3:0]  w_winner;
  logic [3:0]  w_idx;
  logic        w_in_grant;

  // Lowest rotation offset from Last_Ptr+1 wins; offset 16 wraps back onto Last_Ptr itself.
  always_comb begin
    w_winner = r_last_ptr;
    w_idx    = r_last_ptr;
    for (int k = 16; k >= 1; k--) begin
      w_idx = r_last_ptr + 4'(k);
      if (Request_In[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

`ifdef MUX_RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold;
  logic [7:0] w_hold_next;
  logic       r_timeout;
  logic       w_timeout_next;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_last_ptr_next = r_last_ptr;
`ifdef MUX_RR_TIMEOUT_EN
    w_hold_next     = r_hold;
    w_timeout_next  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|Request_In) begin
          w_state_next = ST_GRANT;
          w_owner_next = w_winner;
`ifdef MUX_RR_TIMEOUT_EN
          w_hold_next  = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (!Request_In[r_owner]) begin
          w_state_next    = ST_GAP;
          w_last_ptr_next = r_owner;
        end
`ifdef MUX_RR_TIMEOUT_EN
        else if (r_hold == HOLD_LAST) begin
          w_state_next    = ST_GAP;
          w_last_ptr_next = r_owner;
          w_timeout_next  = 1'b1;
        end else begin
          w_hold_next = r_hold + 8'd1;
        end
`endif
      end
      ST_GAP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state    <= ST_IDLE;
      r_owner    <= 4'd0;
      r_last_ptr <= 4'd15;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_last_ptr <= w_last_ptr_next;
    end
  end

`ifdef MUX_RR_TIMEOUT_EN
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign Timeout_Out = r_timeout;
`else
  assign Timeout_Out = 1'b0;
`endif

  // Outputs decode straight from registered state so reset clears them without waiting for an edge.
  assign w_in_grant = (r_state == ST_GRANT);
  assign Enable_Out = w_in_grant;
  assign Select_Out = r_owner;

  for (genvar gi = 0; gi < 16; gi++) begin : g_grant
    assign Grant_Out[gi] = w_in_grant && (r_owner == 4'(gi));
  end

endmodule

// File: doc/mux_rr_arbiter_16.md
MUX_RR_ARBITER_16 -- requirements
Module: mux_rr_arbiter_16

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum grant duration in clock cycles (range 2..255); used only when MUX_RR_TIMEOUT_EN is defined.
REQ-002 Clock_In  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset_In  input  1  asynchronous, active-high reset.
REQ-004 Request_In  input  16  per-requester request; bit i requests MUX data input i.
REQ-005 Grant_Out  output  16  one-hot grant to the owning requester; all zeros when there is no owner.
REQ-006 Select_Out  output  4  select code for the 16:1 MUX; equals the index of the granted requester.
REQ-007 Enable_Out  output  1  drives the MUX enable; high only while a grant is held.
REQ-008 Timeout_Out  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-009 FSM states: IDLE, GRANT, GAP.
REQ-010 IDLE: if Request_In != 0 at an edge, go to GRANT and register the winner; Grant_Out/Select_Out/Enable_Out become valid after that edge (one-cycle latency).
REQ-011 Winner: first set Request_In bit searching upward from Last_Ptr+1, wrapping 15 -> 0; Last_Ptr is the index of the most recent grant.
REQ-012 GRANT: Grant_Out, Select_Out and Enable_Out are held constant; changes to other Request_In bits are ignored.
REQ-013 GRANT -> GAP when the owner's Request_In bit is low at an edge; Last_Ptr takes the owner index on that edge.
REQ-014 GAP lasts exactly one cycle with Grant_Out=0, Enable_Out=0, and Select_Out holding its last value; it then goes to IDLE, and arbitration happens in IDLE.
REQ-015 Minimum owner-to-owner turnaround is 2 cycles (GAP, then IDLE evaluation); no two Grant_Out bits are ever high together.
REQ-016 Only the owner's bit is examined in GRANT, so simultaneous request drop by the owner and raise by others needs no special case.
REQ-017 A single requester that re-asserts continuously is re-granted after the GAP/IDLE turnaround (Last_Ptr wrap selects it again).
REQ-018 Hold counter is 8 bits; it clears on entry to GRANT and increments each GRANT cycle; it exists only under MUX_RR_TIMEOUT_EN.

Reset
REQ-019 While Reset_In is high: state=IDLE, Grant_Out=0, Select_Out=0, Enable_Out=0, Timeout_Out=0, Last_Ptr=15 (requester 0 has first priority), hold counter=0.
REQ-020 Reset asserted mid-grant clears outputs immediately (asynchronously) with no GAP cycle; the first arbitration occurs at the first edge after Reset_In deasserts.

Configuration
REQ-021 With macro MUX_RR_TIMEOUT_EN defined: GRANT -> GAP once the hold counter reaches MAX_HOLD-1 while the owner is still requesting; Timeout_Out pulses high for exactly the GAP cycle; Last_Ptr is updated to the owner.
REQ-022 Without MUX_RR_TIMEOUT_EN: a grant is held indefinitely until the owner drops its request; Timeout_Out is tied 0; no hold counter is instantiated.

Verification
REQ-023 Reset release with Request_In=16'h0001 -> after 1 edge Grant_Out=16'h0001, Select_Out=0, Enable_Out=1.
REQ-024 Request_In=16'hFFFF held, each owner drops its bit 3 cycles after being granted, then re-raises it -> grants in order 0,1,2,...,15,0 with a 2-cycle gap each, and never more than one grant bit high.
REQ-025 Owner 5 is granted and Request_In changes to 16'h0021 while 5 holds -> grant stays at 5; after 5 drops -> next grant is 0 (wrap past 15).
REQ-026 Reset_In pulsed during grant to 9 -> Grant_Out=0 and Enable_Out=0 immediately; after release with Request_In=16'h0200 -> grant 9 with Last_Ptr=15.
REQ-027 MUX_RR_TIMEOUT_EN defined, MAX_HOLD=4, Request_In=16'h0003 constant -> grant 0 for 4 cycles, Timeout_Out pulse, grant 1 for 4 cycles, and the pattern repeats; without the macro -> grant 0 is held forever with Timeout_Out=0.
REQ-028 Bench drives a MUX_16_1 with Enable_Out/Select_Out and random data -> the MUX output equals the data bit of the granted index every GRANT cycle, and is Z during IDLE/GAP.
